// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, condition-code layout and reset value.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_fn_e;

    localparam int unsigned CC_W  = 3;
    localparam int unsigned CC_ZF = 2;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 0;

    localparam logic [CC_W-1:0] CC_RESET = 3'b100;

    // Place individual flags at their architectural bit positions.
    function automatic logic [CC_W-1:0] cc_pack(input logic zf, input logic sf, input logic of);
        logic [CC_W-1:0] v;
        v        = '0;
        v[CC_ZF] = zf;
        v[CC_SF] = sf;
        v[CC_OF] = of;
        return v;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub/and/xor modulo 2^WIDTH with zero, sign and signed-overflow flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_fn_e          fn,
    output logic [WIDTH-1:0] y,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    logic w_sa;
    logic w_sb;

    assign w_sa = a[WIDTH-1];
    assign w_sb = b[WIDTH-1];

    // Carry-out is dropped; overflow is judged purely on operand/result signs.
    always_comb begin
        y  = '0;
        of = 1'b0;
        case (fn)
            ALU_ADD: begin
                y  = a + b;
                of = (w_sa == w_sb) && (y[WIDTH-1] != w_sa);
            end
            ALU_SUB: begin
                y  = a - b;
                of = (w_sa != w_sb) && (y[WIDTH-1] != w_sa);
            end
            ALU_AND: y = a & b;
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

    assign zf = (y == '0);
    assign sf = y[WIDTH-1];

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Two-requester ALU front end feeding a one-entry result register and a cc register.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed req0 priority.
module alu_arbiter_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_fn,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_set_cc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_fn,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       cc
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_id;
    logic [CC_W-1:0]  r_cc;

    logic             w_free;
    logic             w_win0;
    logic             w_win1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_gnt;
    alu_fn_e          w_fn;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_y;
    logic             w_zf;
    logic             w_sf;
    logic             w_of;

    // Slot is free when empty or when the consumer drains it this cycle.
    assign w_free = (r_state == ST_EMPTY) || rsp_ready;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic r_prio1;  // high when req1 should win a tie

    assign w_win0 = req0_valid && !(req1_valid && r_prio1);
    assign w_win1 = req1_valid && !(req0_valid && !r_prio1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio1 <= 1'b0;
        end else if (w_gnt) begin
            r_prio1 <= w_gnt0;
        end
    end
`else
    assign w_win0 = req0_valid;
    assign w_win1 = req1_valid && !req0_valid;
`endif

    // rst_n gates the grants so ready drops the instant reset asserts.
    assign w_gnt0 = rst_n && w_free && w_win0;
    assign w_gnt1 = rst_n && w_free && w_win1;
    assign w_gnt  = w_gnt0 || w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_fn = w_gnt1 ? alu_fn_e'(req1_fn) : alu_fn_e'(req0_fn);
    assign w_a  = w_gnt1 ? req1_a : req0_a;
    assign w_b  = w_gnt1 ? req1_b : req0_b;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .a  (w_a),
        .b  (w_b),
        .fn (w_fn),
        .y  (w_y),
        .zf (w_zf),
        .sf (w_sf),
        .of (w_of)
    );

    // Result-register FSM plus the cc register it shares a clock enable with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
            r_cc       <= CC_RESET;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_gnt) begin
                        r_state    <= ST_FULL;
                        r_rsp_id   <= w_gnt1;
                        r_rsp_data <= w_y;
                    end
                end
                ST_FULL: begin
                    if (w_gnt) begin
                        r_rsp_id   <= w_gnt1;
                        r_rsp_data <= w_y;
                    end else if (rsp_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
            if (w_gnt0 && req0_set_cc) begin
                r_cc <= cc_pack(w_zf, w_sf, w_of);
            end
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign cc        = r_cc;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Scoreboard bench for alu_arbiter_ctrl: directed vectors, then randomized traffic
// checked against a behavioural model. Honours ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter_ctrl;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [1:0]   req0_fn = 2'b00;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_set_cc = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [1:0]   req1_fn = 2'b00;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic [2:0]   cc;

    alu_arbiter_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_fn     (req0_fn),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_set_cc (req0_set_cc),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_fn     (req1_fn),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .cc          (cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic [2:0]   cc;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    bit         m_full = 1'b0;
    int         m_last = 1;
    logic [2:0] m_cc = 3'b100;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [1:0] fn, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        case (fn)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Overflow: the exact signed result does not fit back into WIDTH bits.
    function automatic logic ref_of(input logic [1:0] fn, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [W-1:0] y);
        logic signed [W:0] sa, sb, exact, wrapped;
        sa      = $signed({a[W-1], a});
        sb      = $signed({b[W-1], b});
        wrapped = $signed({y[W-1], y});
        if (fn == 2'd0)      exact = sa + sb;
        else if (fn == 2'd1) exact = sa - sb;
        else                 return 1'b0;
        return exact != wrapped;
    endfunction

    function automatic int model_pick(input bit v0, input bit v1, input bit rdy);
        if (m_full && !rdy) return -1;
        if (v0 && v1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic drive_cycle(input bit v0, input logic [1:0] f0, input logic [W-1:0] a0,
                               input logic [W-1:0] b0, input bit sc, input bit v1,
                               input logic [1:0] f1, input logic [W-1:0] a1,
                               input logic [W-1:0] b1, input bit rdy,
                               output logic g0, output logic g1);
        int   win;
        exp_t e;
        @(negedge clk);
        req0_valid = v0; req0_fn = f0; req0_a = a0; req0_b = b0; req0_set_cc = sc;
        req1_valid = v1; req1_fn = f1; req1_a = a1; req1_b = b1;
        rsp_ready = rdy;
        win = model_pick(v0, v1, rdy);
        #1;
        g0 = req0_ready;
        g1 = req1_ready;
        chk("req0_ready", W'(req0_ready), W'(win == 0));
        chk("req1_ready", W'(req1_ready), W'(win == 1));
        @(posedge clk);
        #1;
        if (win >= 0) begin
            e.id   = (win == 1);
            e.data = (win == 1) ? ref_result(f1, a1, b1) : ref_result(f0, a0, b0);
            if (win == 0 && sc)
                m_cc = {e.data == '0, e.data[W-1], ref_of(f0, a0, b0, e.data)};
            e.cc   = m_cc;
            q.push_back(e);
            m_last = win;
            m_full = 1'b1;
        end else if (rdy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic apply_reset(input bit check_it);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        if (check_it) begin
            chk("rst_rsp_valid", W'(rsp_valid), W'(0));
            chk("rst_rsp_id", W'(rsp_id), W'(0));
            chk("rst_rsp_data", rsp_data, W'(0));
            chk("rst_cc", W'(cc), W'(3'b100));
            chk("rst_req0_ready", W'(req0_ready), W'(0));
            chk("rst_req1_ready", W'(req1_ready), W'(0));
        end
        q.delete();
        m_full = 1'b0;
        m_last = 1;
        m_cc   = 3'b100;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return {$urandom, $urandom};
            1:       return W'($urandom_range(0, 3));
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Monitor: the queue head is whatever the result register must currently hold.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("rsp_valid", W'(rsp_valid), W'(q.size() != 0));
                if (rsp_valid && q.size() != 0) begin
                    chk("rsp_data", rsp_data, q[0].data);
                    chk("rsp_id", W'(rsp_id), W'(q[0].id));
                    chk("cc", W'(cc), W'(q[0].cc));
                    if (rsp_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic g0, g1;
        int   exp_rr[4];
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_rr = '{0, 1, 0, 1};
`else
        exp_rr = '{0, 0, 0, 0};
`endif
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_set_cc = 1'b1;
        #2;
        apply_reset(1'b1);

        drive_cycle(1, 2'd0, 64'd5, 64'd7, 1, 0, 2'd0, 0, 0, 1, g0, g1);
        chk("add_5_7_data", rsp_data, 64'd12);
        chk("add_5_7_cc", W'(cc), W'(3'b000));
        chk("add_5_7_id", W'(rsp_id), W'(0));

        drive_cycle(1, 2'd1, 64'd3, 64'd3, 1, 0, 2'd0, 0, 0, 1, g0, g1);
        chk("sub_3_3_data", rsp_data, 64'd0);
        chk("sub_3_3_cc", W'(cc), W'(3'b100));

        drive_cycle(0, 2'd0, 0, 0, 0, 1, 2'd3, 64'hFF, 64'hFF, 1, g0, g1);
        chk("xor_req1_data", rsp_data, 64'd0);
        chk("xor_req1_id", W'(rsp_id), W'(1));
        chk("xor_req1_cc", W'(cc), W'(3'b100));

        drive_cycle(1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 0, 2'd0, 0, 0, 1, g0, g1);
        chk("add_ovf_data", rsp_data, 64'h8000_0000_0000_0000);
        chk("add_ovf_cc", W'(cc), W'(3'b011));

        drive_cycle(1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 0, 2'd0, 0, 0, 1, g0, g1);
        chk("add_wrap_data", rsp_data, 64'd0);
        chk("add_wrap_cc", W'(cc), W'(3'b100));

        apply_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 2'd2, 64'hF0, 64'hFF, 0, 1, 2'd3, 64'h1, 64'h2, 1, g0, g1);
            chk("tie_grant_req1", W'(g1), W'(exp_rr[i] == 1));
            chk("tie_grant_req0", W'(g0), W'(exp_rr[i] == 0));
        end

        drive_cycle(1, 2'd0, 64'd100, 64'd23, 0, 0, 2'd0, 0, 0, 1, g0, g1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 2'd0, 0, 0, 0, 1, 2'd3, 64'h1, 64'h1, 0, g0, g1);
            chk("stall_req1_ready", W'(g1), W'(0));
            chk("stall_data_hold", rsp_data, 64'd123);
        end
        drive_cycle(0, 2'd0, 0, 0, 0, 1, 2'd3, 64'hF0, 64'h0F, 1, g0, g1);
        chk("refill_req1_ready", W'(g1), W'(1));
        chk("refill_data", rsp_data, 64'hFF);
        chk("refill_id", W'(rsp_id), W'(1));

        drive_cycle(1, 2'd0, 64'd5, 64'd7, 1, 0, 2'd0, 0, 0, 1, g0, g1);
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b0;
        #3;
        apply_reset(1'b1);

        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), rand_operand(),
                        rand_operand(), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), rand_operand(),
                        rand_operand(), ($urandom_range(0, 9) < 7), g0, g1);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 1, g0, g1);
        end
        @(negedge clk);
        #3;
        chk("scoreboard_empty", W'(q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
